// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - LEGv8 instruction-fetch sequencer: PC, imem addressing, fetch FIFO, redirect and halt.
module imem_fetch_ctrl #(
  parameter int          N          = 32,
  parameter int          PC_W       = 64,
  parameter int          AW         = 8,
  parameter int          DEPTH      = 2,
  parameter logic [N-1:0] HALT_INSTR = 32'hb400001f
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   imem_addr,
  input  logic [N-1:0]    imem_q,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N-1:0]      instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic pop, push, redirect, halt_hit;

  assign imem_addr = pc_q[AW+1:2];
  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];
  assign halted    = (state_q == HALT) && (count_q == '0);

  always_comb begin
    pop      = out_valid && out_ready;
    redirect = br_valid && (state_q != IDLE);
    push     = (state_q == FETCH) && !redirect && ((count_q < DEPTH_C) || pop);
    halt_hit = push && (imem_q == HALT_INSTR);

    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (state_q == IDLE && start) begin
      state_d = FETCH;
    end

    // A redirect discards everything in flight, including a same-cycle pop.
    if (redirect) begin
      state_d = FETCH;
      pc_d    = {br_target[PC_W-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        if (halt_hit) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[tail_q] <= imem_q;
      pc_mem_q[tail_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] HALT_W = 32'hb400001f;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_valid;
  logic [63:0] br_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;

  logic [31:0] rom [256];
  int checks;
  int failures;

  imem_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_valid  (br_valid),
    .br_target (br_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .halted    (halted)
  );

  assign imem_q = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'(i);
    reset = 1'b0;
    start = 1'b0;
    br_valid = 1'b0;
    br_target = '0;
    out_ready = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    step();
    reset = 1'b1;
    step();

    // streaming with decode always ready
    out_ready = 1'b1;
    pulse_start();
    check("s_valid0", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("s_valid", out_valid, 1);
      check("s_pc", out_pc, 64'(i * 4));
      check("s_instr", out_instr, 64'(i));
    end

    // backpressure then release
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    check("bp_addr", imem_addr, 2);
    check("bp_valid", out_valid, 1);
    check("bp_pc", out_pc, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_rel_valid", out_valid, 1);
      check("bp_rel_pc", out_pc, 64'(i * 4));
      check("bp_rel_instr", out_instr, 64'(i));
      step();
    end

    // halt word at index 5
    do_reset();
    rom[5] = HALT_W;
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      step();
      check("h_valid", out_valid, 1);
      check("h_pc", out_pc, 64'(i * 4));
      check("h_halted0", halted, 0);
    end
    check("h_instr", out_instr, HALT_W);
    step();
    check("h_halted", halted, 1);
    check("h_drained", out_valid, 0);
    check("h_addr", imem_addr, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_stay_valid", out_valid, 0);
      check("h_stay_addr", imem_addr, 5);
      check("h_stay_halted", halted, 1);
    end
    rom[5] = 32'd5;

    // redirect while full
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) step();
    check("br_full_pc", out_pc, 0);
    br_valid = 1'b1;
    br_target = 64'h43;
    step();
    br_valid = 1'b0;
    check("br_flush_valid", out_valid, 0);
    check("br_addr", imem_addr, 16);
    out_ready = 1'b1;
    step();
    check("br_valid1", out_valid, 1);
    check("br_pc1", out_pc, 64'h40);
    check("br_instr1", out_instr, 16);
    step();
    check("br_pc2", out_pc, 64'h44);
    check("br_instr2", out_instr, 17);

    // async reset mid-stream, then idle behaviour
    reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_halted", halted, 0);
    check("ar_addr", imem_addr, 0);
    step();
    reset = 1'b1;
    br_valid = 1'b1;
    br_target = 64'h80;
    step();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_valid", out_valid, 0);
      check("idle_addr", imem_addr, 0);
    end

    // PC wrap across the 256-word boundary
    pulse_start();
    br_valid = 1'b1;
    br_target = 64'h3FC;
    step();
    br_valid = 1'b0;
    check("wr_addr0", imem_addr, 255);
    step();
    check("wr_pc0", out_pc, 64'h3FC);
    check("wr_instr0", out_instr, 255);
    check("wr_addr1", imem_addr, 0);
    step();
    check("wr_pc1", out_pc, 64'h400);
    check("wr_instr1", out_instr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the combinational 256-word instruction ROM (imem) of the LEGv8 pipeline.
- Owns the PC and drives the imem word address every cycle.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO, and stops fetching after the program's terminating self-loop (CBZ XZR,#0).

Parameters:
N, 32, instruction width in bits (matches imem N)
PC_W, 64, program counter width in bits
AW, 8, imem word-address width
DEPTH, 2, fetch FIFO entries (power of two, >=2)
HALT_INSTR, 32'hb400001f, encoding that ends fetching

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins fetching from PC 0
imem_addr  out  AW  word address to imem; equals pc[AW+1:2]
imem_q  in  N  imem read data, combinational from imem_addr
br_valid  in  1  redirect request, one cycle
br_target  in  PC_W  redirect byte address
out_valid  out  1  FIFO head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  N  head instruction
out_pc  out  PC_W  byte PC of head instruction
halted  out  1  state==HALT and FIFO empty

Behaviour:
- Reset (reset low, async):
  - pc=0, FIFO count=0, state=IDLE.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, halted=0, imem_addr=0.
  - Asserting reset mid-operation discards all FIFO contents immediately.
- States:
  - IDLE: start -> FETCH. br_valid is ignored in IDLE.
  - FETCH: fetches as described below.
  - HALT: br_valid -> FETCH. start is ignored outside IDLE.
- imem_addr is combinational from the pc register: pc[AW+1:2]. Addresses wrap modulo 256 words by truncation.
- Fetch, in FETCH only. A push occurs when (count<DEPTH) or pop this cycle:
  - {imem_q, pc} is written at the FIFO tail; pc <= pc+4 (mod 2^PC_W).
  - Zero-bubble: one push per cycle sustained when decode is always ready.
- Pop: occurs when out_valid && out_ready. The head advances, and the next entry appears on out_instr/out_pc the following cycle.
- Full FIFO with simultaneous push and pop: both happen, and count is unchanged.
- Empty FIFO: out_valid=0. out_instr/out_pc hold their last value and are don't-care.
- Halt:
  - If the pushed word == HALT_INSTR, the push completes and the state becomes HALT the next cycle.
  - pc is not incremented on that push and stays at the halt instruction's address.
  - The FIFO keeps draining normally.
- Redirect, when br_valid is asserted in FETCH or HALT:
  - FIFO flushed (count=0); a pop in the same cycle is dropped (it counts as flushed).
  - No push that cycle; pc <= {br_target[PC_W-1:2], 2'b00}; state=FETCH.
  - The first redirected instruction is valid at out_* one cycle later.
- Priority: reset > br_valid > halt detection > push/pop.
- Any br_valid simultaneous with a HALT_INSTR push: the redirect wins and the halt word is not pushed.
- Counter rules:
  - count is clog2(DEPTH)+1 bits wide.
  - Head/tail pointers wrap modulo DEPTH.
  - count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset, then start, imem model holds ROM[i]=i, out_ready=1 -> out_valid rises 1 cycle after start; out_pc 0,4,8,... on consecutive cycles; out_instr 0,1,2,...; one instruction per cycle.
- out_ready=0 for 5 cycles after start -> exactly 2 entries (PC 0,4) held, imem_addr frozen at 2; raise out_ready -> PCs 0,4,8 delivered in order with no gap, no duplicate, no loss.
- Place 32'hb400001f at word 5, out_ready=1 -> PCs 0..20 delivered, no PC 24 ever fetched, halted=1 one cycle after PC 20 is popped, imem_addr stays 5.
- br_valid with br_target=64'h43 while FIFO full -> out_valid=0 next cycle, then out_pc=64'h40 with instr ROM[16]; flushed entries never appear.
- Assert reset low mid-stream with FIFO non-empty -> out_valid=0, halted=0, imem_addr=0 immediately, without waiting for a clock edge; after release nothing happens until start.
- PC wrap: redirect to 64'h3FC -> imem_addr 255 then 0; out_pc 64'h3FC then 64'h400.
